// File: rtl/plot_sink.sv
// plot_sink: receives pixel plot requests over valid/ready, buffers them in a
// small FIFO and replays them onto the vga_adapter plot port. It also runs the
// full-screen clear sweep, so drawers never drive the adapter directly.
module plot_sink #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned X_MAX        = 159,
  parameter int unsigned Y_MAX        = 119,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  input  logic       clear_start,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       clear_done,
  output logic       range_err
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW = AW + 1;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  typedef enum logic {ST_STREAM = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  pix_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]   r_count, w_count_nxt;
  logic            r_pop_vld;
  pix_t            r_pop;
  logic            r_pending, w_pending_nxt;
  logic            r_sweep_end, w_sweep_end_nxt;
  logic [XW-1:0]   r_cx, w_cx_nxt;
  logic [YW-1:0]   r_cy, w_cy_nxt;
  logic [XW-1:0]   r_x, w_x_nxt;
  logic [YW-1:0]   r_y, w_y_nxt;
  logic [2:0]      r_colour, w_colour_nxt;
  logic            r_plot, w_plot_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_rerr;
  logic            r_ready, w_ready_nxt;

  logic            w_accept, w_in_range, w_push, w_pop;
  logic            w_pend_set, w_clear_go, w_last;

  assign w_accept    = req_valid & r_ready;
  assign w_in_range  = (req_x <= XW'(X_MAX)) && (req_y <= YW'(Y_MAX));
  assign w_push      = w_accept & w_in_range;
  assign w_pop       = (r_state == ST_STREAM) && (r_count != '0);
  assign w_count_nxt = r_count + NW'(w_push) - NW'(w_pop);
  assign w_pend_set  = clear_start && (r_state == ST_STREAM) && !r_pending;
  assign w_clear_go  = (r_state == ST_STREAM) && r_pending && (r_count == '0) && !r_pop_vld;
  assign w_last      = (r_cx == XW'(X_MAX)) && (r_cy == YW'(Y_MAX));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_STREAM;
    else          r_state <= w_state_nxt;
  end

  // Next-state: STREAM -> CLEAR once drained, CLEAR -> STREAM after the sweep ends
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_STREAM) begin
      if (w_clear_go) w_state_nxt = ST_CLEAR;
    end else if (r_sweep_end) begin
      w_state_nxt = ST_STREAM;
    end
  end

  // Output/next-value logic for the plot port, sweep counters and status flags
  always_comb begin
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_colour_nxt    = r_colour;
    w_plot_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_pending_nxt   = r_pending | w_pend_set;
    w_sweep_end_nxt = 1'b0;
    w_cx_nxt        = r_cx;
    w_cy_nxt        = r_cy;
    if (r_state == ST_STREAM) begin
      if (r_pop_vld) begin
        w_x_nxt      = r_pop.px;
        w_y_nxt      = r_pop.py;
        w_colour_nxt = r_pop.pc;
        w_plot_nxt   = 1'b1;
      end
      if (w_clear_go) begin
        w_cx_nxt = '0;
        w_cy_nxt = '0;
      end
    end else if (r_sweep_end) begin
      w_done_nxt    = 1'b1;
      w_pending_nxt = 1'b0;
    end else begin
      w_x_nxt         = r_cx;
      w_y_nxt         = r_cy;
      w_colour_nxt    = CLEAR_COLOUR;
      w_plot_nxt      = 1'b1;
      w_sweep_end_nxt = w_last;
      if (r_cx == XW'(X_MAX)) begin
        w_cx_nxt = '0;
        w_cy_nxt = r_cy + YW'(1);
      end else begin
        w_cx_nxt = r_cx + XW'(1);
      end
    end
    w_busy_nxt  = (w_count_nxt != '0) | w_pop | w_pending_nxt | (w_state_nxt == ST_CLEAR);
    w_ready_nxt = (w_count_nxt != NW'(FIFO_DEPTH)) & ~w_pending_nxt & (w_state_nxt == ST_STREAM);
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pix_t'({req_x, req_y, req_colour});
  end

  // FIFO pointers, pop stage, sweep counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_vld   <= 1'b0;
      r_pop       <= '0;
      r_pending   <= 1'b0;
      r_sweep_end <= 1'b0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_colour    <= '0;
      r_plot      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rerr      <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_pop    <= r_mem[r_rd_ptr];
      end
      r_count     <= w_count_nxt;
      r_pop_vld   <= w_pop;
      r_pending   <= w_pending_nxt;
      r_sweep_end <= w_sweep_end_nxt;
      r_cx        <= w_cx_nxt;
      r_cy        <= w_cy_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_colour    <= w_colour_nxt;
      r_plot      <= w_plot_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rerr      <= w_accept & ~w_in_range;
      r_ready     <= w_ready_nxt;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign clear_done = r_done;
  assign range_err  = r_rerr;
  assign req_ready  = r_ready;

endmodule

// File: tb/tb_plot_sink.sv
// Testbench for plot_sink: directed single-request vectors from a table plus
// hand-written sequences for streaming, clear sweeps and reset mid-clear.
module tb_plot_sink;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;
  logic       clear_start;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       clear_done;
  logic       range_err;

  plot_sink dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .clear_start(clear_start),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .clear_done(clear_done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Plot monitor: first n_pre pixels must match pre_px, the rest a clear sweep
  logic [17:0] pre_px [10];
  int  n_pre = 0;
  bit  mon_on = 0;
  bit  rdy_chk = 0;
  int  cyc = 0;
  int  pix_n, err_n, done_n, rdy_err, first_cyc, last_cyc;

  always @(negedge clk) begin
    logic [17:0] e;
    int k;
    cyc++;
    if (!mon_on) begin
      pix_n = 0; err_n = 0; done_n = 0; rdy_err = 0; first_cyc = 0; last_cyc = 0;
    end else begin
      if (plot) begin
        if (pix_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        if (pix_n < n_pre) e = pre_px[pix_n];
        else begin
          k = pix_n - n_pre;
          e = {8'(k % 160), 7'(k / 160), 3'b000};
        end
        if ({x, y, colour} != e) err_n++;
        pix_n++;
      end
      if (clear_done) done_n++;
      if (rdy_chk && done_n == 0 && req_ready) rdy_err++;
    end
  end

  typedef struct {
    logic [7:0] vx;
    logic [6:0] vy;
    logic [2:0] vc;
    logic       bad;
  } vec_t;

  vec_t vt [6];

  // One isolated request; entered and left just after a posedge
  task automatic run_vec(input vec_t v);
    req_x = v.vx; req_y = v.vy; req_colour = v.vc; req_valid = 1'b1;
    @(negedge clk); chk("ready_before_accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("range_err_n1", range_err, v.bad);
    chk("plot_n1", plot, 0);
    chk("busy_n1", busy, !v.bad);
    @(negedge clk);
    chk("range_err_n2", range_err, 0);
    chk("plot_n2", plot, 0);
    @(negedge clk);
    chk("plot_n3", plot, !v.bad);
    if (!v.bad) begin
      chk("x_n3", x, v.vx);
      chk("y_n3", y, v.vy);
      chk("colour_n3", colour, v.vc);
    end
    @(negedge clk);
    chk("plot_n4", plot, 0);
    chk("busy_n4", busy, 0);
    @(posedge clk); #1;
  endtask

  // Push pre_px[0..n-1] with req_valid held, advancing only on accepted edges
  task automatic push_seq(input int n);
    int i = 0;
    for (int t = 0; t < 200 && i < n; t++) begin
      {req_x, req_y, req_colour} = pre_px[i];
      req_valid = 1'b1;
      begin
        logic r;
        @(negedge clk); r = req_ready;
        @(posedge clk); #1;
        if (r) i++;
      end
    end
    req_valid = 1'b0;
    chk("push_seq_accepted", i, n);
  endtask

  task automatic pulse_clear();
    clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
  endtask

  // Optional pre-fill, clear, optional re-pulse mid-sweep, then full checks
  task automatic run_clear(input int npre, input bit mid_pulse);
    mon_on = 0; rdy_chk = 0; n_pre = npre;
    @(negedge clk); mon_on = 1;
    @(posedge clk); #1;
    if (npre > 0) push_seq(npre);
    pulse_clear();
    rdy_chk = 1;
    if (mid_pulse) begin
      for (int t = 0; t < 3000 && pix_n < npre + 1000; t++) @(negedge clk);
      chk("mid_sweep_reached", int'(pix_n >= npre + 1000), 1);
      @(posedge clk); #1;
      pulse_clear();
    end
    for (int t = 0; t < 25000 && done_n == 0; t++) @(negedge clk);
    chk("clear_done_seen", done_n, 1);
    repeat (40) @(negedge clk);
    chk("clear_pixel_count", pix_n, npre + 19200);
    chk("clear_pixel_errs", err_n, 0);
    chk("clear_done_count", done_n, 1);
    chk("ready_low_during_clear", rdy_err, 0);
    chk("ready_after_clear", req_ready, 1);
    chk("busy_after_clear", busy, 0);
    rdy_chk = 0; mon_on = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0] = '{vx: 8'd79,  vy: 7'd63,  vc: 3'b101, bad: 1'b0};
    vt[1] = '{vx: 8'd159, vy: 7'd119, vc: 3'b111, bad: 1'b0};
    vt[2] = '{vx: 8'd0,   vy: 7'd0,   vc: 3'b010, bad: 1'b0};
    vt[3] = '{vx: 8'd160, vy: 7'd0,   vc: 3'b001, bad: 1'b1};
    vt[4] = '{vx: 8'd0,   vy: 7'd120, vc: 3'b001, bad: 1'b1};
    vt[5] = '{vx: 8'd255, vy: 7'd127, vc: 3'b110, bad: 1'b1};

    reset_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_colour = '0;
    clear_start = 1'b0;
    #12;
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xyc", int'({x, y, colour}), 0);
    chk("rst_done_err", int'({clear_done, range_err}), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("ready_after_reset", req_ready, 1);
    @(posedge clk); #1;

    // Single requests, in range and out of range
    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Ten back-to-back requests stream in order without gaps
    for (int i = 0; i < 10; i++) pre_px[i] = {8'(i * 10), 7'(i * 5 + 3), 3'(i)};
    mon_on = 0; n_pre = 10;
    @(negedge clk); mon_on = 1;
    @(posedge clk); #1;
    push_seq(10);
    repeat (8) @(negedge clk);
    chk("stream_count", pix_n, 10);
    chk("stream_errs", err_n, 0);
    chk("stream_no_gaps", last_cyc - first_cyc, 9);
    chk("stream_busy_idle", busy, 0);
    mon_on = 0;
    @(posedge clk); #1;

    // Three queued pixels drain, then the full sweep
    pre_px[0] = {8'd12, 7'd34, 3'b011};
    pre_px[1] = {8'd159, 7'd0, 3'b100};
    pre_px[2] = {8'd1, 7'd119, 3'b110};
    run_clear(3, 1'b0);

    // Second clear_start mid-sweep is ignored
    run_clear(0, 1'b1);

    // Reset in the middle of a sweep
    mon_on = 0; n_pre = 0;
    @(negedge clk); mon_on = 1;
    @(posedge clk); #1;
    pulse_clear();
    for (int t = 0; t < 8000 && pix_n < 5000; t++) @(negedge clk);
    chk("sweep_reached_5000", int'(pix_n >= 5000), 1);
    chk("sweep_errs_pre_reset", err_n, 0);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("async_rst_plot", plot, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_xyc", int'({x, y, colour}), 0);
    chk("async_rst_ready", req_ready, 0);
    mon_on = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_plot", plot, 0);
    @(posedge clk); #1;
    run_vec(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
